reg_file_rename: RTL and testbench

- Architectural register file (x0-x31) with per-register rename tags, directly downstream of the reorder buffer.
- Consumes ROB commit writes and ROB new-tail allocations, and tracks which ROB entry will produce each register.
- Resolves decoder operand lookups to a value or to a pending ROB tag, querying the ROB for completed-but-uncommitted results.
- Sits between the decoder and reservation stations/LSB on the issue path.

---
 rtl/reg_file_rename_pkg.sv | 46 ++++
 rtl/reg_file_rename.sv | 111 +++++++++++
 tb/tb_reg_file_rename.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_rename_pkg.sv
// Shared widths, the operand lookup result type and the lookup priority
// resolution used by the register file with rename tags.
package reg_file_rename_pkg;

   localparam int unsigned ROB_WIDTH_BIT = 4;
   localparam int unsigned REG_NUM       = 32;
   localparam int unsigned REG_IDX_W     = 5;
   localparam int unsigned DATA_W        = 32;

   localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic [DATA_W-1:0]        val;
      logic                     dep_valid;
      logic [ROB_WIDTH_BIT-1:0] dep;
   } lookup_t;

   // Operand resolution: zero reg, commit bypass, ROB bypass, pending tag, stored value.
   function automatic lookup_t resolve(
      input logic                     is_zero,
      input logic                     commit_hit,
      input logic [DATA_W-1:0]        commit_val,
      input logic                     busy,
      input logic [ROB_WIDTH_BIT-1:0] tag,
      input logic                     rob_ready,
      input logic [DATA_W-1:0]        rob_val,
      input logic [DATA_W-1:0]        value
   );
      lookup_t res;
      res = '0;
      if (is_zero) begin
         res = '0;
      end else if (busy && commit_hit) begin
         res.val = commit_val;
      end else if (busy && rob_ready) begin
         res.val = rob_val;
      end else if (busy) begin
         res.dep_valid = 1'b1;
         res.dep       = tag;
      end else begin
         res.val = value;
      end
      return res;
   endfunction

endpackage

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register rename tags; resolves decoder
// operands to a value or to the ROB entry that will produce it.
module reg_file_rename
   import reg_file_rename_pkg::*;
(
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     rdy_in,
   input  logic                     clear,

   input  logic                     commit_valid,
   input  logic [REG_IDX_W-1:0]     commit_reg,
   input  logic [DATA_W-1:0]        commit_val,
   input  logic [ROB_WIDTH_BIT-1:0] commit_rob_id,

   input  logic                     rename_valid,
   input  logic [REG_IDX_W-1:0]     rename_reg,
   input  logic [ROB_WIDTH_BIT-1:0] rename_rob_id,

   input  logic [REG_IDX_W-1:0]     rs1_reg,
   input  logic [REG_IDX_W-1:0]     rs2_reg,

   output logic [ROB_WIDTH_BIT-1:0] rob_rs1_id,
   input  logic                     rob_rs1_ready,
   input  logic [DATA_W-1:0]        rob_rs1_val,
   output logic [ROB_WIDTH_BIT-1:0] rob_rs2_id,
   input  logic                     rob_rs2_ready,
   input  logic [DATA_W-1:0]        rob_rs2_val,

   output logic [DATA_W-1:0]        rs1_val,
   output logic                     rs1_dep_valid,
   output logic [ROB_WIDTH_BIT-1:0] rs1_dep,
   output logic [DATA_W-1:0]        rs2_val,
   output logic                     rs2_dep_valid,
   output logic [ROB_WIDTH_BIT-1:0] rs2_dep
);

   logic [DATA_W-1:0]        value_q [REG_NUM];
   logic [ROB_WIDTH_BIT-1:0] tag_q   [REG_NUM];
   logic [REG_NUM-1:0]       busy_q;

   logic [REG_NUM-1:0]       commit_sel;
   logic [REG_NUM-1:0]       rename_sel;

   lookup_t                  rs1_res;
   lookup_t                  rs2_res;
   logic                     rs1_commit_hit;
   logic                     rs2_commit_hit;

   // One-hot write selects; x0 is never selected so it stays zero forever.
   always_comb begin
      commit_sel = '0;
      rename_sel = '0;
      for (int i = 1; i < REG_NUM; i++) begin
         commit_sel[i] = commit_valid && (commit_reg == REG_IDX_W'(i));
         rename_sel[i] = rename_valid && (rename_reg == REG_IDX_W'(i));
      end
   end

   // Clear drops every pending tag; rename beats a same-cycle commit on busy/tag.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < REG_NUM; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= '0;
         end
         busy_q <= '0;
      end else if (rdy_in) begin
         for (int i = 0; i < REG_NUM; i++) begin
            if (commit_sel[i]) begin
               value_q[i] <= commit_val;
            end
            if (clear) begin
               busy_q[i] <= 1'b0;
               tag_q[i]  <= '0;
            end else if (rename_sel[i]) begin
               busy_q[i] <= 1'b1;
               tag_q[i]  <= rename_rob_id;
            end else if (commit_sel[i] && (tag_q[i] == commit_rob_id)) begin
               busy_q[i] <= 1'b0;
            end
         end
      end
   end

   // Combinational lookups against pre-edge state.
   always_comb begin
      rs1_commit_hit = commit_valid && (commit_reg == rs1_reg)
                       && (tag_q[rs1_reg] == commit_rob_id);
      rs2_commit_hit = commit_valid && (commit_reg == rs2_reg)
                       && (tag_q[rs2_reg] == commit_rob_id);

      rs1_res = resolve(rs1_reg == ZERO_REG, rs1_commit_hit, commit_val,
                        busy_q[rs1_reg], tag_q[rs1_reg],
                        rob_rs1_ready, rob_rs1_val, value_q[rs1_reg]);
      rs2_res = resolve(rs2_reg == ZERO_REG, rs2_commit_hit, commit_val,
                        busy_q[rs2_reg], tag_q[rs2_reg],
                        rob_rs2_ready, rob_rs2_val, value_q[rs2_reg]);
   end

   assign rob_rs1_id    = tag_q[rs1_reg];
   assign rob_rs2_id    = tag_q[rs2_reg];

   assign rs1_val       = rs1_res.val;
   assign rs1_dep_valid = rs1_res.dep_valid;
   assign rs1_dep       = rs1_res.dep;
   assign rs2_val       = rs2_res.val;
   assign rs2_dep_valid = rs2_res.dep_valid;
   assign rs2_dep       = rs2_res.dep;

endmodule

// File: tb/tb_reg_file_rename.sv
// Bench for reg_file_rename: directed and random stimulus, a reference model of
// the register/rename state, and a scoreboard queue consumed by a monitor.
module tb_reg_file_rename;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b0;
   logic        clear = 1'b0;
   logic        commit_valid = 1'b0;
   logic [4:0]  commit_reg = '0;
   logic [31:0] commit_val = '0;
   logic [3:0]  commit_rob_id = '0;
   logic        rename_valid = 1'b0;
   logic [4:0]  rename_reg = '0;
   logic [3:0]  rename_rob_id = '0;
   logic [4:0]  rs1_reg = '0;
   logic [4:0]  rs2_reg = '0;
   logic [3:0]  rob_rs1_id;
   logic        rob_rs1_ready = 1'b0;
   logic [31:0] rob_rs1_val = '0;
   logic [3:0]  rob_rs2_id;
   logic        rob_rs2_ready = 1'b0;
   logic [31:0] rob_rs2_val = '0;
   logic [31:0] rs1_val;
   logic        rs1_dep_valid;
   logic [3:0]  rs1_dep;
   logic [31:0] rs2_val;
   logic        rs2_dep_valid;
   logic [3:0]  rs2_dep;

   always #5 clk_in = ~clk_in;

   reg_file_rename dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
      .commit_valid(commit_valid), .commit_reg(commit_reg),
      .commit_val(commit_val), .commit_rob_id(commit_rob_id),
      .rename_valid(rename_valid), .rename_reg(rename_reg),
      .rename_rob_id(rename_rob_id),
      .rs1_reg(rs1_reg), .rs2_reg(rs2_reg),
      .rob_rs1_id(rob_rs1_id), .rob_rs1_ready(rob_rs1_ready), .rob_rs1_val(rob_rs1_val),
      .rob_rs2_id(rob_rs2_id), .rob_rs2_ready(rob_rs2_ready), .rob_rs2_val(rob_rs2_val),
      .rs1_val(rs1_val), .rs1_dep_valid(rs1_dep_valid), .rs1_dep(rs1_dep),
      .rs2_val(rs2_val), .rs2_dep_valid(rs2_dep_valid), .rs2_dep(rs2_dep)
   );

   typedef struct {
      logic [31:0] v1;
      logic        dv1;
      logic [3:0]  d1;
      logic [3:0]  id1;
      logic [31:0] v2;
      logic        dv2;
      logic [3:0]  d2;
      logic [3:0]  id2;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;

   // Reference state: what each register holds, whether a ROB entry owes it, and which one.
   logic [31:0] m_val  [32];
   bit          m_busy [32];
   logic [3:0]  m_tag  [32];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) begin
         m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
   endfunction

   function automatic void model_lookup(input int r, input logic rr, input logic [31:0] rv,
                                        output logic [31:0] v, output logic dv, output logic [3:0] d);
      v = '0; dv = 1'b0; d = '0;
      if (r == 0) return;
      if (commit_valid && int'(commit_reg) == r && m_busy[r] && m_tag[r] == commit_rob_id)
         v = commit_val;
      else if (m_busy[r] && rr)
         v = rv;
      else if (m_busy[r]) begin
         dv = 1'b1; d = m_tag[r];
      end else
         v = m_val[r];
   endfunction

   function automatic void model_edge();
      int cr, rn;
      if (!rdy_in) return;
      cr = int'(commit_reg);
      rn = int'(rename_reg);
      if (commit_valid && cr != 0) begin
         m_val[cr] = commit_val;
         if (m_tag[cr] == commit_rob_id && !(rename_valid && rn == cr))
            m_busy[cr] = 1'b0;
      end
      if (clear) begin
         for (int i = 0; i < 32; i++) begin
            m_busy[i] = 1'b0; m_tag[i] = '0;
         end
      end else if (rename_valid && rn != 0) begin
         m_busy[rn] = 1'b1; m_tag[rn] = rename_rob_id;
      end
   endfunction

   // Inputs are already driven (just after a rising edge): queue the expected lookup, then clock.
   task automatic step();
      exp_t e;
      if (!rst_in) model_reset();
      model_lookup(int'(rs1_reg), rob_rs1_ready, rob_rs1_val, e.v1, e.dv1, e.d1);
      model_lookup(int'(rs2_reg), rob_rs2_ready, rob_rs2_val, e.v2, e.dv2, e.d2);
      e.id1 = m_tag[rs1_reg];
      e.id2 = m_tag[rs2_reg];
      exp_q.push_back(e);
      @(posedge clk_in);
      if (rst_in) model_edge();
      #1;
   endtask

   task automatic idle();
      rdy_in = 1'b1; clear = 1'b0; commit_valid = 1'b0; rename_valid = 1'b0;
      rob_rs1_ready = 1'b0; rob_rs2_ready = 1'b0;
   endtask

   task automatic do_rename(input logic [4:0] r, input logic [3:0] id);
      idle(); rename_valid = 1'b1; rename_reg = r; rename_rob_id = id; step();
   endtask

   // Monitor: compares DUT outputs mid-cycle against the oldest queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_in);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rob_rs1_id", 32'(rob_rs1_id), 32'(e.id1));
            check("rs1_dep_valid", 32'(rs1_dep_valid), 32'(e.dv1));
            check("rs1_val", rs1_val, e.v1);
            if (e.dv1) check("rs1_dep", 32'(rs1_dep), 32'(e.d1));
            check("rob_rs2_id", 32'(rob_rs2_id), 32'(e.id2));
            check("rs2_dep_valid", 32'(rs2_dep_valid), 32'(e.dv2));
            check("rs2_val", rs2_val, e.v2);
            if (e.dv2) check("rs2_dep", 32'(rs2_dep), 32'(e.d2));
         end
      end
   end

   initial begin
      model_reset();
      @(posedge clk_in);
      #1;
      // Reset state
      rst_in = 1'b0; rs1_reg = 5'd5; rs2_reg = 5'd9;
      step(); step();
      rst_in = 1'b1;

      // Rename then pending lookup, then ROB bypass
      do_rename(5'd5, 4'd3);
      idle(); rs1_reg = 5'd5; step();
      rob_rs1_ready = 1'b1; rob_rs1_val = 32'hAB; step();

      // Commit clears busy with same-cycle bypass
      idle(); commit_valid = 1'b1; commit_reg = 5'd5; commit_val = 32'h1234;
      commit_rob_id = 4'd3; rs2_reg = 5'd5; step();
      idle(); step();

      // Stale commit, then commit/rename collision
      do_rename(5'd7, 4'd2);
      do_rename(5'd7, 4'd6);
      idle(); commit_valid = 1'b1; commit_reg = 5'd7; commit_val = 32'd9;
      commit_rob_id = 4'd2; rs1_reg = 5'd7; step();
      idle(); step();
      idle(); commit_valid = 1'b1; commit_reg = 5'd7; commit_val = 32'h77;
      commit_rob_id = 4'd6; rename_valid = 1'b1; rename_reg = 5'd7; rename_rob_id = 4'd1; step();
      idle(); step();

      // Clear with rdy_in=1, then with rdy_in=0
      idle(); commit_valid = 1'b1; commit_reg = 5'd3; commit_val = 32'h33; commit_rob_id = 4'd0; step();
      do_rename(5'd3, 4'd4);
      do_rename(5'd8, 4'd5);
      idle(); clear = 1'b1; rs1_reg = 5'd3; rs2_reg = 5'd8; step();
      idle(); step();
      rs1_reg = 5'd7; step();
      do_rename(5'd3, 4'd4);
      do_rename(5'd8, 4'd5);
      idle(); rdy_in = 1'b0; clear = 1'b1; rs1_reg = 5'd3; rs2_reg = 5'd8; step();
      idle(); step();

      // x0 writes ignored; rdy_in low freezes rename
      idle(); rename_valid = 1'b1; rename_reg = 5'd0; rename_rob_id = 4'd2;
      commit_valid = 1'b1; commit_reg = 5'd0; commit_val = 32'hFF; rs1_reg = 5'd0; step();
      idle(); step();
      idle(); rdy_in = 1'b0; rename_valid = 1'b1; rename_reg = 5'd4; rename_rob_id = 4'd1;
      rs1_reg = 5'd4; step();
      idle(); step();

      // Random traffic over a small register window to force collisions
      for (int n = 0; n < 600; n++) begin
         idle();
         rst_in        = ($urandom_range(0, 249) != 0);
         rdy_in        = ($urandom_range(0, 9) != 0);
         clear         = ($urandom_range(0, 29) == 0);
         commit_valid  = $urandom_range(0, 1) == 1;
         commit_reg    = 5'($urandom_range(0, 7));
         commit_val    = $urandom;
         commit_rob_id = ($urandom_range(0, 1) == 1) ? m_tag[commit_reg] : 4'($urandom);
         rename_valid  = $urandom_range(0, 1) == 1;
         rename_reg    = 5'($urandom_range(0, 7));
         rename_rob_id = 4'($urandom);
         rs1_reg       = 5'($urandom_range(0, 7));
         rs2_reg       = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         rob_rs1_ready = ($urandom_range(0, 2) == 0);
         rob_rs1_val   = $urandom;
         rob_rs2_ready = ($urandom_range(0, 2) == 0);
         rob_rs2_val   = $urandom;
         step();
      end
      rst_in = 1'b1;
      idle();

      repeat (3) @(posedge clk_in);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
